cpu_mem_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the CPU instruction-fetch requester and the data-access requester.
- Sits between the pipeline's inst/data memory interfaces and the single downstream memory/bus bridge.
- Handles one outstanding transaction at a time.
- Data has priority; a bounded-streak rule guarantees fetch progress.

---
 rtl/cpu_mem_arbiter_pkg.sv | 27 ++
 rtl/cpu_mem_arb_pick.sv | 34 +++
 rtl/cpu_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared encodings for the CPU inst/data memory-port arbiter.
package cpu_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Wide enough for MAX_DATA_STREAK up to 15.
    localparam int STREAK_W = 4;

    // Captured request bus layout: {wr, size, addr, wdata}.
    function automatic int mem_req_bus_wd(input int addr_w, input int data_w);
        return 1 + 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/cpu_mem_arb_pick.sv
// Winner selection between fetch and data requesters, with the data-streak next value.
module cpu_mem_arb_pick
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                i_inst_req,
    input  logic                i_data_req,
    input  logic [STREAK_W-1:0] i_streak,
    output logic                o_any,
    output arb_owner_e          o_winner,
    output logic [STREAK_W-1:0] o_streak_nxt
);

    localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DATA_STREAK);

    logic w_force_inst;

    assign o_any        = i_inst_req | i_data_req;
    // A pending fetch that has waited out a full data streak takes the port.
    assign w_force_inst = i_inst_req && (i_streak == MAX_S);

    always_comb begin
        o_winner     = OWN_INST;
        o_streak_nxt = '0;
        if (i_data_req && !w_force_inst) begin
            o_winner = OWN_DATA;
            if (i_inst_req) begin
                o_streak_nxt = (i_streak == MAX_S) ? MAX_S : i_streak + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-outstanding arbiter sharing one SRAM-like port between fetch and data accesses.
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int MEM_REQ_BUS_WD = mem_req_bus_wd(ADDR_W, DATA_W);

    arb_state_e                r_state;
    arb_state_e                w_state_nxt;
    arb_owner_e                r_owner;
    arb_owner_e                w_winner;
    logic [STREAK_W-1:0]       r_streak;
    logic [STREAK_W-1:0]       w_streak_nxt;
    logic [MEM_REQ_BUS_WD-1:0] r_req_bus;
    logic [MEM_REQ_BUS_WD-1:0] w_req_bus_nxt;
    logic                      r_live;
    logic                      w_any;
    logic                      w_grant;

    cpu_mem_arb_pick #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_pick (
        .i_inst_req   (inst_req),
        .i_data_req   (data_req),
        .i_streak     (r_streak),
        .o_any        (w_any),
        .o_winner     (w_winner),
        .o_streak_nxt (w_streak_nxt)
    );

    // r_live keeps every output quiet for the first cycle out of reset.
    assign w_grant       = (r_state == ST_IDLE) && r_live && w_any;
    assign w_req_bus_nxt = (w_winner == OWN_DATA)
                         ? {data_wr, data_size, data_addr, data_wdata}
                         : {1'b0, SIZE_WORD, inst_addr, {DATA_W{1'b0}}};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner   <= OWN_INST;
            r_streak  <= '0;
            r_req_bus <= '0;
            r_live    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_grant) begin
                r_owner   <= w_winner;
                r_streak  <= w_streak_nxt;
                r_req_bus <= w_req_bus_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant)     w_state_nxt = ST_REQ;
            ST_REQ:  if (mem_addr_ok) w_state_nxt = ST_RESP;
            ST_RESP: if (mem_data_ok) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    inst_addr_ok = (w_winner == OWN_INST);
                    data_addr_ok = (w_winner == OWN_DATA);
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                {mem_wr, mem_size, mem_addr, mem_wdata} = r_req_bus;
            end
            ST_RESP: begin
                // Responses outside RESP are stray and never reach the requesters.
                if (mem_data_ok) begin
                    if (r_owner == OWN_DATA) begin
                        data_data_ok = 1'b1;
                        data_rdata   = mem_rdata;
                    end else begin
                        inst_data_ok = 1'b1;
                        inst_rdata   = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: queued requesters, a scripted memory, and a checking monitor.
module tb_cpu_mem_arbiter;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
    } resp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    cpu_mem_arbiter #(
        .MAX_DATA_STREAK(4),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    ack_dly = 0;
    int    resp_dly = 0;
    logic  spurious = 1'b0;
    req_t  inst_q[$];
    req_t  data_q[$];
    req_t  exp_mem[$];
    logic  exp_grant[$];
    resp_t exp_resp[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C1D_0001;
        if (a == 32'h0000_1003) return 32'h0000_00AB;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic req_t mk(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd);
        req_t r;
        r.wr = wr; r.size = sz; r.addr = a; r.wdata = wd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic owner, input req_t r);
        resp_t e;
        e.owner = owner;
        e.rdata = r.wr ? 32'h0 : mem_model(r.addr);
        exp_grant.push_back(owner);
        exp_mem.push_back(r);
        exp_resp.push_back(e);
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return inst_addr_ok;
            1:       return data_addr_ok;
            default: return mem_req;
        endcase
    endfunction

    task automatic wait_cond(input int w, input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!sig(w) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!sig(w)) begin
            n_vec++; n_err++;
            $display("FAIL %s: signal stayed 0, required 1 within 200 cycles", name);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (((inst_q.size() + data_q.size() + exp_grant.size() + exp_mem.size()
                 + exp_resp.size()) != 0 || inst_req || data_req || mem_req) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_vec++; n_err++;
            $display("FAIL %s: %0d responses still outstanding, required 0", name, exp_resp.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Fetch requester
    initial begin
        logic acc;
        inst_req = 1'b0; inst_addr = '0;
        forever begin
            @(negedge clk);
            acc = inst_req && inst_addr_ok;
            @(posedge clk); #1;
            if (acc) begin inst_req = 1'b0; inst_addr = '0; end
            if (!inst_req && inst_q.size() > 0) begin
                inst_addr = inst_q.pop_front().addr;
                inst_req  = 1'b1;
            end
        end
    end

    // Data requester
    initial begin
        logic acc;
        req_t r;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        forever begin
            @(negedge clk);
            acc = data_req && data_addr_ok;
            @(posedge clk); #1;
            if (acc) begin
                data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
            end
            if (!data_req && data_q.size() > 0) begin
                r = data_q.pop_front();
                data_wr = r.wr; data_size = r.size; data_addr = r.addr; data_wdata = r.wdata;
                data_req = 1'b1;
            end
        end
    end

    // Downstream memory with scripted accept/response delays
    initial begin
        int          cnt;
        int          ph;
        logic        wr_acc;
        logic [31:0] addr_acc;
        cnt = 0; ph = 0; wr_acc = 1'b0; addr_acc = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
            if (!resetn) begin
                ph = 0; cnt = 0;
            end else if (ph == 0) begin
                if (mem_req) begin
                    if (cnt >= ack_dly) begin
                        mem_addr_ok = 1'b1; wr_acc = mem_wr; addr_acc = mem_addr;
                        ph = 1; cnt = 0;
                    end else cnt++;
                end else if (spurious) begin
                    mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678; spurious = 1'b0;
                end
            end else begin
                if (cnt >= resp_dly) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = wr_acc ? 32'h0 : mem_model(addr_acc);
                    ph = 0; cnt = 0;
                end else cnt++;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [3:0] pulses;
        logic       prev_mreq;
        int         last_grant;
        int         last_aok;
        logic       eg;
        req_t       em;
        resp_t      er;
        prev_mreq = 1'b0; last_grant = -100; last_aok = -100;
        forever begin
            @(negedge clk);
            pulses = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
            if (!resetn) begin
                chk("reset_ctrl_outputs", {pulses, mem_req, mem_wr, mem_size}, 96'h0);
                chk("reset_bus_outputs", {mem_addr, mem_wdata, inst_rdata | data_rdata}, 96'h0);
                prev_mreq = 1'b0; last_grant = -100; last_aok = -100;
                continue;
            end
            n_vec++;
            if ($countones(pulses) > 1) begin
                n_err++;
                $display("FAIL pulses_at_most_one: got %b required at most one bit set", pulses);
            end
            if (!inst_data_ok) chk("inst_rdata_gated", inst_rdata, 96'h0);
            if (!data_data_ok) chk("data_rdata_gated", data_rdata, 96'h0);
            if (inst_addr_ok || data_addr_ok) begin
                if (exp_grant.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_grant: got owner %b required no grant", data_addr_ok);
                end else begin
                    eg = exp_grant.pop_front();
                    chk("grant_owner", data_addr_ok, eg);
                end
                n_vec++;
                if (cyc - last_grant < 3) begin
                    n_err++;
                    $display("FAIL grant_spacing: got %0d cycles required >= 3", cyc - last_grant);
                end
                last_grant = cyc; last_aok = cyc;
            end
            if (mem_req && !prev_mreq) chk("mem_req_latency", cyc - last_aok, 96'd1);
            if (mem_req && mem_addr_ok) begin
                if (exp_mem.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_mem_req: got addr %h required none", mem_addr);
                end else begin
                    em = exp_mem.pop_front();
                    chk("mem_fields", {mem_wr, mem_size, mem_addr, mem_wdata}, em);
                end
            end
            if (inst_data_ok || data_data_ok) begin
                chk("data_ok_with_mem_data_ok", mem_data_ok, 96'd1);
                if (exp_resp.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_data_ok: got %b required none", pulses);
                end else begin
                    er = exp_resp.pop_front();
                    chk("resp_owner", data_data_ok, er.owner);
                    chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, er.rdata);
                end
            end
            prev_mreq = mem_req;
        end
    end

    // Directed stimulus
    initial begin
        int c0;
        int t;
        resetn = 1'b0;
        ack_dly = 2; resp_dly = 1;
        inst_q.push_back(mk(1'b0, 2'd2, 32'hBFC0_0000, 32'h0));
        expect_txn(1'b0, mk(1'b0, 2'd2, 32'hBFC0_0000, 32'h0));
        repeat (3) begin
            @(negedge clk);
            chk("reset_inst_addr_ok", inst_addr_ok, 96'h0);
        end
        chk("reset_streak", dut.r_streak, 96'h0);
        resetn = 1'b1;
        #1;
        chk("post_release_quiet", {inst_addr_ok, data_addr_ok, mem_req}, 96'h0);

        // Single fetch with cycle-exact timing
        wait_cond(0, "fetch_addr_ok");
        c0 = cyc;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("fetch_cycle", cyc - c0, k);
            chk("fetch_mem_req", mem_req, (k <= 3) ? 96'd1 : 96'd0);
            chk("fetch_inst_data_ok", inst_data_ok, (k == 5) ? 96'd1 : 96'd0);
            if (k <= 3) chk("fetch_mem_addr", {mem_wr, mem_size, mem_addr}, {1'b0, 2'd2, 32'hBFC0_0000});
            if (k == 5) chk("fetch_rdata", inst_rdata, 96'h3C1D_0001);
        end
        drain("single_fetch");

        // Simultaneous requests: data wins, fetch next
        ack_dly = 0; resp_dly = 0;
        inst_q.push_back(mk(1'b0, 2'd2, 32'h0000_0100, 32'h0));
        data_q.push_back(mk(1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF));
        expect_txn(1'b1, mk(1'b1, 2'd2, 32'h0000_0200, 32'hDEAD_BEEF));
        expect_txn(1'b0, mk(1'b0, 2'd2, 32'h0000_0100, 32'h0));
        wait_cond(1, "simul_data_grant");
        @(negedge clk);
        chk("simul_streak_after_data", dut.r_streak, 96'd1);
        drain("simultaneous");
        chk("simul_streak_after_inst", dut.r_streak, 96'd0);

        // Starvation bound: D,D,D,D,I,D,D
        for (int i = 0; i < 6; i++) data_q.push_back(mk(1'b0, 2'd2, 32'h300 + 32'(4 * i), 32'h0));
        inst_q.push_back(mk(1'b0, 2'd2, 32'h0000_0400, 32'h0));
        for (int i = 0; i < 4; i++) expect_txn(1'b1, mk(1'b0, 2'd2, 32'h300 + 32'(4 * i), 32'h0));
        expect_txn(1'b0, mk(1'b0, 2'd2, 32'h0000_0400, 32'h0));
        for (int i = 4; i < 6; i++) expect_txn(1'b1, mk(1'b0, 2'd2, 32'h300 + 32'(4 * i), 32'h0));
        wait_cond(0, "starve_inst_grant");
        @(negedge clk);
        chk("starve_streak_after_inst", dut.r_streak, 96'd0);
        drain("starvation");

        // Stalled downstream: request held, fetch stays pending
        ack_dly = 10;
        data_q.push_back(mk(1'b1, 2'd1, 32'h0000_2002, 32'h0000_BEEF));
        expect_txn(1'b1, mk(1'b1, 2'd1, 32'h0000_2002, 32'h0000_BEEF));
        wait_cond(2, "stall_mem_req");
        inst_q.push_back(mk(1'b0, 2'd2, 32'h0000_0500, 32'h0));
        expect_txn(1'b0, mk(1'b0, 2'd2, 32'h0000_0500, 32'h0));
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            chk("stall_mem_req_held", {mem_req, mem_addr_ok}, 96'b10);
            chk("stall_mem_bus", {mem_wr, mem_size, mem_addr, mem_wdata},
                {1'b1, 2'd1, 32'h0000_2002, 32'h0000_BEEF});
            chk("stall_no_addr_ok", {inst_addr_ok, data_addr_ok}, 96'h0);
        end
        drain("stalled");
        ack_dly = 0;

        // Stray mem_data_ok in IDLE must be ignored
        spurious = 1'b1;
        @(negedge clk);
        chk("stray_data_ok_ignored", {inst_data_ok, data_data_ok}, 96'h0);
        chk("stray_rdata_ignored", {inst_rdata, data_rdata}, 96'h0);
        repeat (2) @(negedge clk);

        // Byte read
        data_q.push_back(mk(1'b0, 2'd0, 32'h0000_1003, 32'h0));
        expect_txn(1'b1, mk(1'b0, 2'd0, 32'h0000_1003, 32'h0));
        drain("byte_read");

        // Asynchronous reset while in RESP
        resp_dly = 2;
        data_q.push_back(mk(1'b0, 2'd2, 32'h0000_0600, 32'h0));
        exp_grant.push_back(1'b1);
        exp_mem.push_back(mk(1'b0, 2'd2, 32'h0000_0600, 32'h0));
        t = 0;
        do begin
            @(posedge clk); #2;
            t++;
        end while (!mem_data_ok && t < 50);
        chk("rst_pre_data_ok", {data_data_ok, data_rdata}, {1'b1, 32'hA5A5_0600});
        #1 resetn = 1'b0;
        #1;
        chk("rst_ctrl_drop", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req}, 96'h0);
        chk("rst_rdata_drop", data_rdata, 96'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        resp_dly = 0;
        inst_q.push_back(mk(1'b0, 2'd2, 32'h0000_0700, 32'h0));
        expect_txn(1'b0, mk(1'b0, 2'd2, 32'h0000_0700, 32'h0));
        drain("after_reset_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
